// File: rtl/dma_reg_file_if.sv
// Register-file view shared by the DMA priority and timing stages.
// Latency: none, plain wires carrying registered values.
// Backpressure: none; consumers sample the registers every cycle.
interface dmaRegIf;
  logic [15:0] currAddrReg [4];
  logic [15:0] currWordReg [4];
  logic [15:0] baseAddrReg [4];
  logic [15:0] baseWordReg [4];
  logic [5:0]  modeReg     [4];
  logic [7:0]  commandReg;
  logic [7:0]  requestReg;
  logic [7:0]  maskReg;
  logic [7:0]  tempReg;
  logic [7:0]  statusReg;

  modport REG (
    output currAddrReg, currWordReg, baseAddrReg, baseWordReg, modeReg,
    output commandReg, requestReg, maskReg, tempReg, statusReg
  );

  modport CONS (
    input currAddrReg, currWordReg, baseAddrReg, baseWordReg, modeReg,
    input commandReg, requestReg, maskReg, tempReg, statusReg
  );
endinterface

// File: rtl/dma_reg_file.sv
// CPU-programmable 8237A-style register file with per-transfer address/count update and TC handling.
// Latency: writes/updates visible 1 cycle after the commit edge; DB_OUT valid 1 cycle after IOR_N sampled low.
// Backpressure: none; every strobe edge and every updateEn pulse is accepted in its own cycle.
module dma_reg_file #(
  parameter int NUM_CH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CS_N,
  input  logic       IOR_N,
  input  logic       IOW_N,
  input  logic [3:0] A,
  input  logic [7:0] DB_IN,
  output logic [7:0] DB_OUT,
  output logic       DB_OE,
  input  logic [3:0] DREQ,
  input  logic       updateEn,
  input  logic [1:0] updateCh,
  input  logic       tempLoad,
  input  logic [7:0] tempIn,
  output logic [3:0] tcOut,
  dmaRegIf.REG       REG
);

  logic [15:0] curr_addr_q [NUM_CH];
  logic [15:0] curr_addr_d [NUM_CH];
  logic [15:0] curr_word_q [NUM_CH];
  logic [15:0] curr_word_d [NUM_CH];
  logic [15:0] base_addr_q [NUM_CH];
  logic [15:0] base_addr_d [NUM_CH];
  logic [15:0] base_word_q [NUM_CH];
  logic [15:0] base_word_d [NUM_CH];
  logic [5:0]  mode_q      [NUM_CH];
  logic [5:0]  mode_d      [NUM_CH];
  logic [7:0]  cmd_q, cmd_d;
  logic [3:0]  req_q, req_d;
  logic [3:0]  mask_q, mask_d;
  logic [7:0]  temp_q, temp_d;
  logic [3:0]  tc_flag_q, tc_flag_d;
  logic [3:0]  dreq_q, dreq_d;
  logic [3:0]  tc_q, tc_d;
  logic [7:0]  db_out_q, db_out_d;
  logic        bpf_q, bpf_d;
  logic        iow_n_q, iow_n_d;
  logic        ior_n_q, ior_n_d;

  logic        wr_commit;
  logic        rd_commit;
  logic        mclr;
  logic [1:0]  n;
  logic        tc_hit;
  logic        autoinit;
  logic [15:0] rd_word;
  logic [7:0]  rd_byte;

  // Strobe edge detect: commit only on the first cycle a strobe is seen low.
  assign wr_commit = !CS_N && !IOW_N && iow_n_q;
  assign rd_commit = !CS_N && !IOR_N && ior_n_q;
  assign mclr      = wr_commit && (A == 4'hD);
  assign n         = A[2:1];
  assign DB_OE     = !CS_N && !IOR_N;

  // Next-state: transfer update first, then CPU access, then TC side effects, master clear last.
  always_comb begin
    iow_n_d     = IOW_N;
    ior_n_d     = IOR_N;
    curr_addr_d = curr_addr_q;
    curr_word_d = curr_word_q;
    base_addr_d = base_addr_q;
    base_word_d = base_word_q;
    mode_d      = mode_q;
    cmd_d       = cmd_q;
    req_d       = req_q;
    mask_d      = mask_q;
    temp_d      = temp_q;
    tc_flag_d   = tc_flag_q;
    dreq_d      = DREQ;
    tc_d        = '0;
    db_out_d    = db_out_q;
    bpf_d       = bpf_q;
    tc_hit      = 1'b0;
    autoinit    = 1'b0;
    rd_word     = A[0] ? curr_word_q[n] : curr_addr_q[n];
    rd_byte     = 8'h00;

    if (tempLoad) temp_d = tempIn;

    if (updateEn) begin
      autoinit = mode_q[updateCh][2];
      tc_hit   = (curr_word_q[updateCh] == 16'h0000);
      if (tc_hit && autoinit) begin
        curr_addr_d[updateCh] = base_addr_q[updateCh];
        curr_word_d[updateCh] = base_word_q[updateCh];
      end else begin
        curr_addr_d[updateCh] = mode_q[updateCh][3] ? curr_addr_q[updateCh] - 16'd1
                                                    : curr_addr_q[updateCh] + 16'd1;
        curr_word_d[updateCh] = curr_word_q[updateCh] - 16'd1;
      end
    end

    if (!A[3])            rd_byte = bpf_q ? rd_word[15:8] : rd_word[7:0];
    else if (A == 4'h8)   rd_byte = {dreq_q, tc_flag_q};
    else if (A == 4'hD)   rd_byte = temp_q;

    if (rd_commit) begin
      db_out_d = rd_byte;
      if (!A[3]) bpf_d = !bpf_q;
      if (A == 4'h8) tc_flag_d = '0;
    end

    // CPU byte write lands after the update so it wins on the same register.
    if (wr_commit) begin
      if (!A[3]) begin
        bpf_d = !bpf_q;
        if (A[0]) begin
          if (bpf_q) begin
            base_word_d[n][15:8] = DB_IN;
            curr_word_d[n][15:8] = DB_IN;
          end else begin
            base_word_d[n][7:0]  = DB_IN;
            curr_word_d[n][7:0]  = DB_IN;
          end
        end else begin
          if (bpf_q) begin
            base_addr_d[n][15:8] = DB_IN;
            curr_addr_d[n][15:8] = DB_IN;
          end else begin
            base_addr_d[n][7:0]  = DB_IN;
            curr_addr_d[n][7:0]  = DB_IN;
          end
        end
      end else begin
        case (A[2:0])
          3'd0:    cmd_d = DB_IN;
          3'd1:    req_d[DB_IN[1:0]] = DB_IN[2];
          3'd2:    mask_d[DB_IN[1:0]] = DB_IN[2];
          3'd3:    mode_d[DB_IN[1:0]] = DB_IN[7:2];
          3'd4:    bpf_d = 1'b0;
          3'd6:    mask_d = 4'h0;
          3'd7:    mask_d = DB_IN[3:0];
          default: ;
        endcase
      end
    end

    // TC effects override a same-cycle status clear or mask/request write.
    if (tc_hit) begin
      tc_flag_d[updateCh] = 1'b1;
      tc_d[updateCh]      = 1'b1;
      req_d[updateCh]     = 1'b0;
      if (!autoinit) mask_d[updateCh] = 1'b1;
    end

    // Master clear discards everything computed above, including the update.
    if (mclr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        curr_addr_d[i] = '0;
        curr_word_d[i] = '0;
        base_addr_d[i] = '0;
        base_word_d[i] = '0;
        mode_d[i]      = '0;
      end
      cmd_d     = '0;
      req_d     = '0;
      mask_d    = 4'hF;
      temp_d    = '0;
      tc_flag_d = '0;
      dreq_d    = '0;
      tc_d      = '0;
      db_out_d  = '0;
      bpf_d     = 1'b0;
    end
  end

  // State register; strobe history resets low so a strobe held through reset never commits.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        curr_addr_q[i] <= '0;
        curr_word_q[i] <= '0;
        base_addr_q[i] <= '0;
        base_word_q[i] <= '0;
        mode_q[i]      <= '0;
      end
      cmd_q     <= '0;
      req_q     <= '0;
      mask_q    <= 4'hF;
      temp_q    <= '0;
      tc_flag_q <= '0;
      dreq_q    <= '0;
      tc_q      <= '0;
      db_out_q  <= '0;
      bpf_q     <= 1'b0;
      iow_n_q   <= 1'b0;
      ior_n_q   <= 1'b0;
    end else begin
      curr_addr_q <= curr_addr_d;
      curr_word_q <= curr_word_d;
      base_addr_q <= base_addr_d;
      base_word_q <= base_word_d;
      mode_q      <= mode_d;
      cmd_q       <= cmd_d;
      req_q       <= req_d;
      mask_q      <= mask_d;
      temp_q      <= temp_d;
      tc_flag_q   <= tc_flag_d;
      dreq_q      <= dreq_d;
      tc_q        <= tc_d;
      db_out_q    <= db_out_d;
      bpf_q       <= bpf_d;
      iow_n_q     <= iow_n_d;
      ior_n_q     <= ior_n_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_reg_out
    assign REG.currAddrReg[g] = curr_addr_q[g];
    assign REG.currWordReg[g] = curr_word_q[g];
    assign REG.baseAddrReg[g] = base_addr_q[g];
    assign REG.baseWordReg[g] = base_word_q[g];
    assign REG.modeReg[g]     = mode_q[g];
  end

  assign REG.commandReg = cmd_q;
  assign REG.requestReg = {4'h0, req_q};
  assign REG.maskReg    = {4'h0, mask_q};
  assign REG.tempReg    = temp_q;
  assign REG.statusReg  = {dreq_q, tc_flag_q};
  assign DB_OUT         = db_out_q;
  assign tcOut          = tc_q;

endmodule

// File: tb/tb_dma_reg_file.sv
// Directed bench for dma_reg_file: programming, reads, TC/autoinit, mask/request, master clear, strobe edges.
// Latency: inputs driven on the falling edge, outputs sampled on a later falling edge.
// Backpressure: not applicable.
module tb_dma_reg_file;
  logic       CLK = 1'b0;
  logic       RESET;
  logic       CS_N, IOR_N, IOW_N;
  logic [3:0] A;
  logic [7:0] DB_IN;
  logic [7:0] DB_OUT;
  logic       DB_OE;
  logic [3:0] DREQ;
  logic       updateEn;
  logic [1:0] updateCh;
  logic       tempLoad;
  logic [7:0] tempIn;
  logic [3:0] tcOut;

  int errors = 0;
  int checks = 0;
  logic [7:0] rd;
  logic       oe;

  dmaRegIf reg_if ();

  dma_reg_file #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .A(A), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DREQ(DREQ),
    .updateEn(updateEn), .updateCh(updateCh), .tempLoad(tempLoad), .tempIn(tempIn),
    .tcOut(tcOut), .REG(reg_if)
  );

  always #5 CLK = ~CLK;

  task automatic cpu_write(input logic [3:0] addr, input logic [7:0] data);
    @(negedge CLK);
    CS_N = 1'b0; IOW_N = 1'b0; A = addr; DB_IN = data;
    @(negedge CLK);
    CS_N = 1'b1; IOW_N = 1'b1;
  endtask

  task automatic cpu_read(input logic [3:0] addr, output logic [7:0] data, output logic oe_s);
    @(negedge CLK);
    CS_N = 1'b0; IOR_N = 1'b0; A = addr;
    #1 oe_s = DB_OE;
    @(negedge CLK);
    data = DB_OUT;
    CS_N = 1'b1; IOR_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (reg_if.maskReg !== 8'h0F) begin errors++; $display("FAIL reset_mask got=%h exp=0f", reg_if.maskReg); end
    checks++; if (reg_if.commandReg !== 8'h00) begin errors++; $display("FAIL reset_cmd got=%h exp=00", reg_if.commandReg); end
    checks++; if (reg_if.statusReg !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", reg_if.statusReg); end
    checks++; if (reg_if.currWordReg[3] !== 16'h0000) begin errors++; $display("FAIL reset_word3 got=%h exp=0000", reg_if.currWordReg[3]); end
    checks++; if (DB_OUT !== 8'h00 || tcOut !== 4'h0 || DB_OE !== 1'b0) begin errors++; $display("FAIL reset_outs got=%h/%b/%b exp=00/0000/0", DB_OUT, tcOut, DB_OE); end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_addr_bytes();
    cpu_write(4'hC, 8'h00);
    cpu_write(4'h2, 8'h34);
    cpu_write(4'h2, 8'h12);
    checks++; if (reg_if.baseAddrReg[1] !== 16'h1234) begin errors++; $display("FAIL base_addr1 got=%h exp=1234", reg_if.baseAddrReg[1]); end
    checks++; if (reg_if.currAddrReg[1] !== 16'h1234) begin errors++; $display("FAIL curr_addr1 got=%h exp=1234", reg_if.currAddrReg[1]); end
    cpu_write(4'hC, 8'h00);
    cpu_read(4'h2, rd, oe);
    checks++; if (rd !== 8'h34) begin errors++; $display("FAIL read_lo got=%h exp=34", rd); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL db_oe got=%b exp=1", oe); end
    cpu_read(4'h2, rd, oe);
    checks++; if (rd !== 8'h12) begin errors++; $display("FAIL read_hi got=%h exp=12", rd); end
  endtask

  task automatic test_tc_autoinit();
    DREQ = 4'hA;
    cpu_write(4'hC, 8'h00);
    cpu_write(4'h1, 8'h01);
    cpu_write(4'h1, 8'h00);
    cpu_write(4'hB, 8'h10);
    checks++; if (reg_if.modeReg[0] !== 6'h04) begin errors++; $display("FAIL mode0 got=%h exp=04", reg_if.modeReg[0]); end
    checks++; if (reg_if.currWordReg[0] !== 16'h0001) begin errors++; $display("FAIL word0_prog got=%h exp=0001", reg_if.currWordReg[0]); end
    @(negedge CLK); updateEn = 1'b1; updateCh = 2'd0;
    @(negedge CLK);
    checks++; if (reg_if.currWordReg[0] !== 16'h0000 || tcOut !== 4'h0) begin errors++; $display("FAIL upd1 got=%h/%b exp=0000/0000", reg_if.currWordReg[0], tcOut); end
    checks++; if (reg_if.currAddrReg[0] !== 16'h0001) begin errors++; $display("FAIL upd1_addr got=%h exp=0001", reg_if.currAddrReg[0]); end
    @(negedge CLK); updateEn = 1'b0;
    checks++; if (reg_if.currWordReg[0] !== 16'h0001 || reg_if.currAddrReg[0] !== 16'h0000) begin errors++; $display("FAIL reload got=%h/%h exp=0001/0000", reg_if.currWordReg[0], reg_if.currAddrReg[0]); end
    checks++; if (tcOut !== 4'b0001) begin errors++; $display("FAIL tc_pulse got=%b exp=0001", tcOut); end
    checks++; if (reg_if.statusReg !== 8'hA1) begin errors++; $display("FAIL status_tc got=%h exp=a1", reg_if.statusReg); end
    @(negedge CLK);
    checks++; if (tcOut !== 4'b0000) begin errors++; $display("FAIL tc_once got=%b exp=0000", tcOut); end
    cpu_read(4'h8, rd, oe);
    checks++; if (rd !== 8'hA1) begin errors++; $display("FAIL status_rd1 got=%h exp=a1", rd); end
    cpu_read(4'h8, rd, oe);
    checks++; if (rd !== 8'hA0) begin errors++; $display("FAIL status_rd2 got=%h exp=a0", rd); end
  endtask

  task automatic test_tc_noauto();
    cpu_write(4'hB, 8'h26);
    checks++; if (reg_if.modeReg[2] !== 6'h09) begin errors++; $display("FAIL mode2 got=%h exp=09", reg_if.modeReg[2]); end
    cpu_write(4'hE, 8'h00);
    checks++; if (reg_if.maskReg !== 8'h00) begin errors++; $display("FAIL mask_clr got=%h exp=00", reg_if.maskReg); end
    cpu_write(4'h9, 8'h06);
    checks++; if (reg_if.requestReg !== 8'h04) begin errors++; $display("FAIL req_set got=%h exp=04", reg_if.requestReg); end
    @(negedge CLK); updateEn = 1'b1; updateCh = 2'd2;
    @(negedge CLK); updateEn = 1'b0;
    checks++; if (reg_if.currAddrReg[2] !== 16'hFFFF || reg_if.currWordReg[2] !== 16'hFFFF) begin errors++; $display("FAIL decr_wrap got=%h/%h exp=ffff/ffff", reg_if.currAddrReg[2], reg_if.currWordReg[2]); end
    checks++; if (reg_if.maskReg !== 8'h04 || reg_if.requestReg !== 8'h00) begin errors++; $display("FAIL tc_mask_req got=%h/%h exp=04/00", reg_if.maskReg, reg_if.requestReg); end
    checks++; if (tcOut !== 4'b0100 || reg_if.statusReg !== 8'hA4) begin errors++; $display("FAIL tc2 got=%b/%h exp=0100/a4", tcOut, reg_if.statusReg); end
  endtask

  task automatic test_mask_cmd_mclr();
    cpu_write(4'hF, 8'h0A);
    checks++; if (reg_if.maskReg !== 8'h0A) begin errors++; $display("FAIL mask_all got=%h exp=0a", reg_if.maskReg); end
    cpu_write(4'h8, 8'h5C);
    checks++; if (reg_if.commandReg !== 8'h5C) begin errors++; $display("FAIL cmd got=%h exp=5c", reg_if.commandReg); end
    @(negedge CLK); tempLoad = 1'b1; tempIn = 8'h77;
    @(negedge CLK); tempLoad = 1'b0;
    cpu_read(4'hD, rd, oe);
    checks++; if (rd !== 8'h77) begin errors++; $display("FAIL temp_rd got=%h exp=77", rd); end
    DREQ = 4'h0;
    // Master clear with a simultaneous update on ch1 (currWord[1]=0 would otherwise hit TC).
    @(negedge CLK);
    CS_N = 1'b0; IOW_N = 1'b0; A = 4'hD; DB_IN = 8'h00; updateEn = 1'b1; updateCh = 2'd1;
    @(negedge CLK);
    CS_N = 1'b1; IOW_N = 1'b1; updateEn = 1'b0;
    checks++; if (reg_if.maskReg !== 8'h0F || reg_if.commandReg !== 8'h00 || reg_if.tempReg !== 8'h00) begin errors++; $display("FAIL mclr_regs got=%h/%h/%h exp=0f/00/00", reg_if.maskReg, reg_if.commandReg, reg_if.tempReg); end
    checks++; if (reg_if.currAddrReg[1] !== 16'h0000 || reg_if.currWordReg[1] !== 16'h0000 || reg_if.modeReg[2] !== 6'h00) begin errors++; $display("FAIL mclr_ch got=%h/%h/%h exp=0000/0000/00", reg_if.currAddrReg[1], reg_if.currWordReg[1], reg_if.modeReg[2]); end
    checks++; if (tcOut !== 4'h0 || reg_if.statusReg !== 8'h00 || DB_OUT !== 8'h00) begin errors++; $display("FAIL mclr_upd got=%b/%h/%h exp=0000/00/00", tcOut, reg_if.statusReg, DB_OUT); end
  endtask

  task automatic test_strobe_edges();
    @(negedge CLK);
    CS_N = 1'b0; IOW_N = 1'b0; A = 4'h2; DB_IN = 8'h55;
    repeat (5) @(negedge CLK);
    CS_N = 1'b1; IOW_N = 1'b1;
    checks++; if (reg_if.baseAddrReg[1] !== 16'h0055) begin errors++; $display("FAIL long_strobe got=%h exp=0055", reg_if.baseAddrReg[1]); end
    cpu_write(4'h2, 8'hAA);
    checks++; if (reg_if.baseAddrReg[1] !== 16'hAA55) begin errors++; $display("FAIL one_toggle got=%h exp=aa55", reg_if.baseAddrReg[1]); end
    cpu_write(4'hC, 8'h00);
    @(negedge CLK);
    CS_N = 1'b0; IOW_N = 1'b0; A = 4'h2; DB_IN = 8'h11;
    @(negedge CLK);
    checks++; if (reg_if.baseAddrReg[1] !== 16'hAA11) begin errors++; $display("FAIL pre_reset got=%h exp=aa11", reg_if.baseAddrReg[1]); end
    RESET = 1'b1;
    #1;
    checks++; if (reg_if.baseAddrReg[1] !== 16'h0000) begin errors++; $display("FAIL async_reset got=%h exp=0000", reg_if.baseAddrReg[1]); end
    @(negedge CLK); RESET = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (reg_if.baseAddrReg[1] !== 16'h0000 || reg_if.maskReg !== 8'h0F) begin errors++; $display("FAIL no_commit got=%h/%h exp=0000/0f", reg_if.baseAddrReg[1], reg_if.maskReg); end
    CS_N = 1'b1; IOW_N = 1'b1;
    cpu_write(4'h2, 8'h22);
    checks++; if (reg_if.baseAddrReg[1] !== 16'h0022) begin errors++; $display("FAIL fresh_edge got=%h exp=0022", reg_if.baseAddrReg[1]); end
  endtask

  initial begin
    RESET = 1'b1; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; A = 4'h0; DB_IN = 8'h00;
    DREQ = 4'h0; updateEn = 1'b0; updateCh = 2'd0; tempLoad = 1'b0; tempIn = 8'h00;
    test_reset();
    test_addr_bytes();
    test_tc_autoinit();
    test_tc_noauto();
    test_mask_cmd_mclr();
    test_strobe_edges();
    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dma_reg_file.md
# dma_reg_file

Programming-side register file of the 8237A-style DMA controller. Decodes CPU I/O cycles (CS_N/IOR_N/IOW_N, A[3:0], 8-bit data) into the channel address/word-count, mode, command, request, mask, status and temporary registers, and drives them onto the REG modport of dmaRegIf, feeding the priority and timing-FSM stages. Also applies per-transfer address/word-count updates, terminal-count (TC) detection and autoinitialize reload requested by the timing FSM.

## Interface
- NUM_CH, 4, channel count; only 4 is supported.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CS_N  in  1  chip select, active low.
- IOR_N  in  1  I/O read strobe, active low.
- IOW_N  in  1  I/O write strobe, active low.
- A  in  4  register address.
- DB_IN  in  8  CPU write data.
- DB_OUT  out  8  CPU read data, registered.
- DB_OE  out  1  high while CS_N=0 and IOR_N=0.
- DREQ  in  4  synchronized DMA requests, reflected in status[7:4].
- updateEn  in  1  one-cycle pulse from FSM: one transfer completed on updateCh.
- updateCh  in  2  channel being updated.
- tempLoad  in  1  load tempReg from tempIn (memory-to-memory).
- tempIn  in  8  temporary data.
- tcOut  out  4  one-cycle pulse per channel on TC.
- REG  modport  —  drives currAddrReg/currWordReg/baseAddrReg/baseWordReg[0..3] (16b), modeReg[0..3] (6b), commandReg, requestReg, maskReg, tempReg, statusReg (8b).

## Operation
- Write commit: the first CLK edge where CS_N=0, IOW_N=0 and the registered IOW_N was 1. Exactly one commit per strobe.
- Read commit: the first such edge for IOR_N. DB_OUT latches the selected byte and holds until IOR_N rises. Read side effects apply at that same edge.
- Byte pointer FF (bpf): 0 selects the low byte, 1 the high byte. It toggles after every read or write of addresses 0x0–0x7.
- Address map; the channel is n=A[2:1]:
  - 0x0/2/4/6: write updates baseAddr[n] and currAddr[n] byte[bpf]; read returns currAddr[n].
  - 0x1/3/5/7: same behaviour for the word-count registers.
  - 0x8: write sets commandReg. Read returns statusReg, then clears status[3:0].
  - 0x9: write sets requestReg[DB[1:0]] = DB[2].
  - 0xA: write sets maskReg[DB[1:0]] = DB[2].
  - 0xB: write sets modeReg[DB[1:0]] = DB[7:2]. Fields: [5:4] mode, [3] address decrement, [2] autoinit, [1:0] transfer type.
  - 0xC: write clears bpf.
  - 0xD: write is master clear. Read returns tempReg.
  - 0xE: write clears maskReg[3:0].
  - 0xF: write sets maskReg[3:0] = DB[3:0].
  - Any other read returns 0x00.
- requestReg[7:4] and maskReg[7:4] are always 0.
- statusReg[7:4] = DREQ, registered each cycle. statusReg[3:0] = TC flags, sticky until a status read.
- Transfer update (updateEn, ch c):
  - currAddr[c] is decremented if modeReg[c][3]=1, otherwise incremented, modulo 2^16.
  - currWord[c] is decremented.
  - TC occurs when currWord[c]==0x0000 before the decrement. On TC:
    - status[c] is set and tcOut[c] pulses.
    - requestReg[c] is cleared.
    - If autoinit: currAddr/currWord[c] reload from base instead of updating.
    - Otherwise: currWord becomes 0xFFFF and maskReg[c] is set.
- Conflicts and boundaries:
  - CPU write and update to the same register byte in the same cycle: the CPU write wins for that register. TC flag, mask and request effects still apply.
  - TC set and status read in the same cycle: the TC bit remains set.
  - updateEn during master clear: ignored.
- Master clear and RESET: command, status, request, temp, all mode, address and count registers = 0; bpf=0; maskReg=0x0F; DB_OUT=0; tcOut=0.
- RESET mid-strobe: state is cleared immediately. A strobe still low when RESET falls does not commit; a fresh edge is required.

## Timing
- Write data is visible on REG outputs 1 cycle after the commit edge.
- Read: DB_OUT is valid 1 cycle after IOR_N is sampled low. DB_OE is combinational.
- Update: new currAddr/currWord appear 1 cycle after updateEn. tcOut pulses in that same cycle.
- Back-to-back updateEn on consecutive cycles is supported; each pulse produces one update.

## Test plan
- Reset → maskReg=0x0F, all other REG outputs 0, DB_OUT=0.
- Write 0xC, then 0x34 and 0x12 to 0x2 → base/currAddr[1]=0x1234. Two reads of 0x2 return 0x34 then 0x12.
- Program currWord[0]=0x0001 with mode 0x10 (autoinit, incr); send 2 updateEn on ch 0 → currWord goes 0x0000 then reloads to 0x0001; status[0]=1; tcOut[0] pulses once. Read 0x8 → bit0=1; read again → bit0=0.
- Mode 0x24 (decr, no autoinit) on ch2 with currAddr=0x0000, currWord=0x0000 → one update gives currAddr=0xFFFF, currWord=0xFFFF, maskReg[2]=1, requestReg[2]=0.
- Write 0x06 to 0x9, 0x00 to 0xE, 0x0A to 0xF → requestReg=0x04, maskReg=0x00, then maskReg=0x0A. Write 0xD → all registers return to reset values.
- IOW_N held low 5 cycles writing 0x2 → exactly one byte written and one bpf toggle. Assert RESET mid-strobe → no commit after release.
